// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared pipeline definitions: control-bundle layout, NOP encoding, ALUOp codes.
package pipe_pkg;

  localparam int CTRL_WIDTH = 11;

  // Bit positions inside the control bundle
  // {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,RegDst,ALUOp[3:0]}
  localparam int CTRL_REGWRITE = 10;
  localparam int CTRL_MEMTOREG = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [CTRL_WIDTH-1:0] CTRL_NOP = '0;

  typedef enum logic [3:0] {
    ALUOP_ADD   = 4'b0000,
    ALUOP_SUB   = 4'b0001,
    ALUOP_RTYPE = 4'b0010,
    ALUOP_OR    = 4'b0011,
    ALUOP_AND   = 4'b0100,
    ALUOP_SLT   = 4'b0101,
    ALUOP_LUI   = 4'b0110
  } aluop_e;

  function automatic logic ctrl_memread(input logic [CTRL_WIDTH-1:0] c);
    return c[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register, bundled.
interface id_ex_if
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                          Bubble;
  logic                          Flush;
  logic                          Stall;
  logic [CTRL_WIDTH-1:0]         Ctrl_ID;
  logic [DATA_WIDTH-1:0]         PC4_ID;
  logic [DATA_WIDTH-1:0]         ReadData1_ID;
  logic [DATA_WIDTH-1:0]         ReadData2_ID;
  logic [DATA_WIDTH-1:0]         SignExt_ID;
  logic [3*REG_ADDR_WIDTH-1:0]   Instr_ID;

  logic [CTRL_WIDTH-1:0]         Ctrl_EX;
  logic [DATA_WIDTH-1:0]         PC4_EX;
  logic [DATA_WIDTH-1:0]         ReadData1_EX;
  logic [DATA_WIDTH-1:0]         ReadData2_EX;
  logic [DATA_WIDTH-1:0]         SignExt_EX;
  logic [REG_ADDR_WIDTH-1:0]     RS_EX;
  logic [REG_ADDR_WIDTH-1:0]     RT_EX;
  logic [REG_ADDR_WIDTH-1:0]     RD_EX;
  logic                          MemRead_EX;
  logic                          Valid_EX;
  logic [CNT_WIDTH-1:0]          BubbleCount;

  // Decode/hazard side drives the ID view and observes the EX view
  modport master (
    output Bubble, Flush, Stall, Ctrl_ID, PC4_ID, ReadData1_ID, ReadData2_ID,
           SignExt_ID, Instr_ID,
    input  Ctrl_EX, PC4_EX, ReadData1_EX, ReadData2_EX, SignExt_EX,
           RS_EX, RT_EX, RD_EX, MemRead_EX, Valid_EX, BubbleCount
  );

  // The pipeline register itself
  modport slave (
    input  Bubble, Flush, Stall, Ctrl_ID, PC4_ID, ReadData1_ID, ReadData2_ID,
           SignExt_ID, Instr_ID,
    output Ctrl_EX, PC4_EX, ReadData1_EX, ReadData2_EX, SignExt_EX,
           RS_EX, RT_EX, RD_EX, MemRead_EX, Valid_EX, BubbleCount
  );
endinterface

// File: rtl/id_ex_pipe_reg_field_reg.sv
// Generic field register: sync active-low reset, sync clear, load enable.
// Clear beats enable so a flush still lands while the stage is stalled.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  // Next state: clear > load > hold
  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = '0;
    else if (en_i) q_d = d_i;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble insertion, flush, stall hold and a
// saturating bubble counter. Priority per edge: reset > Flush > Stall > Bubble > load.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic  clk,
  input  logic  reset,
  id_ex_if.slave bus
);
  localparam int RAW = REG_ADDR_WIDTH;
  localparam int DW  = DATA_WIDTH;

  // Bubble is ignored under Stall (hazard logic re-asserts it); Flush is not.
  logic en, clr, bub_eff;
  assign en      = ~bus.Stall;
  assign bub_eff = bus.Bubble & ~bus.Stall;
  assign clr     = bus.Flush | bub_eff;

  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [4*DW-1:0]       data_q;
  logic [3*RAW-1:0]      addr_q;

  pipe_field_reg #(.W(CTRL_WIDTH)) u_ctrl (
    .clk(clk), .reset(reset), .en_i(en), .clr_i(clr),
    .d_i(bus.Ctrl_ID), .q_o(ctrl_q)
  );

  pipe_field_reg #(.W(4*DW)) u_data (
    .clk(clk), .reset(reset), .en_i(en), .clr_i(clr),
    .d_i({bus.PC4_ID, bus.ReadData1_ID, bus.ReadData2_ID, bus.SignExt_ID}),
    .q_o(data_q)
  );

  // Clearing the addresses keeps a stale RT_EX from re-triggering the hazard
  pipe_field_reg #(.W(3*RAW)) u_addr (
    .clk(clk), .reset(reset), .en_i(en), .clr_i(clr),
    .d_i(bus.Instr_ID), .q_o(addr_q)
  );

  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Valid and bubble-count next state; flushes are not counted
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.Flush)        valid_d = 1'b0;
    else if (bus.Stall)   valid_d = valid_q;
    else if (bus.Bubble) begin
      valid_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    else                  valid_d = 1'b1;
  end

  // Valid and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Ctrl_EX      = ctrl_q;
  assign bus.PC4_EX       = data_q[4*DW-1:3*DW];
  assign bus.ReadData1_EX = data_q[3*DW-1:2*DW];
  assign bus.ReadData2_EX = data_q[2*DW-1:DW];
  assign bus.SignExt_EX   = data_q[DW-1:0];
  assign bus.RS_EX        = addr_q[3*RAW-1:2*RAW];
  assign bus.RT_EX        = addr_q[2*RAW-1:RAW];
  assign bus.RD_EX        = addr_q[RAW-1:0];
  assign bus.MemRead_EX   = ctrl_memread(ctrl_q);
  assign bus.Valid_EX     = valid_q;
  assign bus.BubbleCount  = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed table-driven bench for id_ex_pipe_reg plus a saturation sequence
// on a narrow-counter instance.
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rst_sat;

  id_ex_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();
  id_ex_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  sbus ();

  id_ex_pipe_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  id_ex_pipe_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(rst_sat), .bus(sbus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data operands derived from one tag: pc4=d, rd1=3d, rd2=5d, sext=7d (0 stays 0)
  typedef struct {
    logic        rst;
    logic        bub;
    logic        fl;
    logic        st;
    logic [10:0] ctrl;
    logic [31:0] data;
    logic [14:0] instr;
    logic [10:0] e_ctrl;
    logic [31:0] e_data;
    logic [14:0] e_instr;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, bub, fl, st, input logic [10:0] ctrl,
                     input logic [31:0] data, input logic [14:0] instr,
                     input logic [10:0] e_ctrl, input logic [31:0] e_data,
                     input logic [14:0] e_instr, input logic e_valid,
                     input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.bub = bub; v.fl = fl; v.st = st;
    v.ctrl = ctrl; v.data = data; v.instr = instr;
    v.e_ctrl = e_ctrl; v.e_data = e_data; v.e_instr = e_instr;
    v.e_valid = e_valid; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0; rst_sat = 1'b0;
    bus.Bubble = 0; bus.Flush = 0; bus.Stall = 0;
    bus.Ctrl_ID = '0; bus.PC4_ID = '0; bus.ReadData1_ID = '0;
    bus.ReadData2_ID = '0; bus.SignExt_ID = '0; bus.Instr_ID = '0;
    sbus.Bubble = 0; sbus.Flush = 0; sbus.Stall = 0;
    sbus.Ctrl_ID = '0; sbus.PC4_ID = '0; sbus.ReadData1_ID = '0;
    sbus.ReadData2_ID = '0; sbus.SignExt_ID = '0; sbus.Instr_ID = '0;

    //   rst bub fl st  ctrl     data          instr     | e_ctrl  e_data     e_instr  v  cnt
    add(0, 0, 0, 0, 11'h7FF, 32'hDEADBEEF, 15'h7FFF,   11'h000, 32'h0,     15'h0000, 0, 0); // reset
    add(0, 1, 1, 1, 11'h7FF, 32'hDEADBEEF, 15'h7FFF,   11'h000, 32'h0,     15'h0000, 0, 0); // reset beats all
    add(1, 0, 0, 0, 11'h720, 32'h100,      15'h7500,   11'h720, 32'h100,   15'h7500, 1, 0); // lw $t0
    add(1, 1, 0, 0, 11'h412, 32'h200,      15'h212A,   11'h000, 32'h0,     15'h0000, 0, 1); // load-use bubble
    add(1, 0, 0, 0, 11'h412, 32'h200,      15'h212A,   11'h412, 32'h200,   15'h212A, 1, 1); // add proceeds
    add(1, 0, 0, 0, 11'h412, 32'h300,      15'h1234,   11'h412, 32'h300,   15'h1234, 1, 1);
    add(1, 0, 0, 1, 11'h7FF, 32'h400,      15'h7FFF,   11'h412, 32'h300,   15'h1234, 1, 1); // stall
    add(1, 1, 0, 1, 11'h0FF, 32'h500,      15'h0F0F,   11'h412, 32'h300,   15'h1234, 1, 1); // bubble ignored
    add(1, 0, 0, 1, 11'h555, 32'h600,      15'h5555,   11'h412, 32'h300,   15'h1234, 1, 1);
    add(1, 0, 0, 0, 11'h0A5, 32'h700,      15'h0ABC,   11'h0A5, 32'h700,   15'h0ABC, 1, 1); // released
    add(1, 1, 1, 0, 11'h720, 32'h800,      15'h7500,   11'h000, 32'h0,     15'h0000, 0, 1); // flush+bubble
    add(1, 1, 0, 0, 11'h720, 32'h800,      15'h7500,   11'h000, 32'h0,     15'h0000, 0, 2); // bubble
    add(1, 0, 0, 0, 11'h720, 32'h900,      15'h7500,   11'h720, 32'h900,   15'h7500, 1, 2);
    add(1, 0, 1, 1, 11'h412, 32'hA00,      15'h212A,   11'h000, 32'h0,     15'h0000, 0, 2); // flush beats stall
    add(1, 0, 0, 0, 11'h412, 32'hA00,      15'h212A,   11'h412, 32'hA00,   15'h212A, 1, 2);
    add(0, 0, 0, 1, 11'h7FF, 32'hB00,      15'h7FFF,   11'h000, 32'h0,     15'h0000, 0, 0); // reset in stall
    add(1, 0, 0, 0, 11'h123, 32'hB00,      15'h4321,   11'h123, 32'hB00,   15'h4321, 1, 0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      reset = v.rst; bus.Bubble = v.bub; bus.Flush = v.fl; bus.Stall = v.st;
      bus.Ctrl_ID = v.ctrl; bus.PC4_ID = v.data; bus.ReadData1_ID = v.data * 3;
      bus.ReadData2_ID = v.data * 5; bus.SignExt_ID = v.data * 7; bus.Instr_ID = v.instr;
      @(posedge clk); #1;
      check($sformatf("v%0d ctrl", i), 32'(bus.Ctrl_EX), 32'(v.e_ctrl));
      check($sformatf("v%0d pc4", i),  bus.PC4_EX,       v.e_data);
      check($sformatf("v%0d rd1", i),  bus.ReadData1_EX, v.e_data * 3);
      check($sformatf("v%0d rd2", i),  bus.ReadData2_EX, v.e_data * 5);
      check($sformatf("v%0d sext", i), bus.SignExt_EX,   v.e_data * 7);
      check($sformatf("v%0d rs", i),   32'(bus.RS_EX), 32'(v.e_instr[14:10]));
      check($sformatf("v%0d rt", i),   32'(bus.RT_EX), 32'(v.e_instr[9:5]));
      check($sformatf("v%0d rd", i),   32'(bus.RD_EX), 32'(v.e_instr[4:0]));
      check($sformatf("v%0d memrd", i), 32'(bus.MemRead_EX), 32'(v.e_ctrl[8]));
      check($sformatf("v%0d valid", i), 32'(bus.Valid_EX), 32'(v.e_valid));
      check($sformatf("v%0d cnt", i),  32'(bus.BubbleCount), 32'(v.e_cnt));
    end

    // Narrow counter: 20 back-to-back bubbles must stop at 4'hF
    @(negedge clk);
    rst_sat = 1'b0;
    @(posedge clk); #1;
    check("sat reset", 32'(sbus.BubbleCount), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rst_sat = 1'b1; sbus.Bubble = 1'b1;
      @(posedge clk); #1;
      check($sformatf("sat b%0d", k), 32'(sbus.BubbleCount), (k > 15) ? 32'd15 : 32'(k));
      check($sformatf("sat v%0d", k), 32'(sbus.Valid_EX), 32'd0);
    end
    // Counter holds at saturation once bubbles stop
    @(negedge clk);
    sbus.Bubble = 1'b0; sbus.Ctrl_ID = 11'h720;
    @(posedge clk); #1;
    check("sat hold", 32'(sbus.BubbleCount), 32'd15);
    check("sat load valid", 32'(sbus.Valid_EX), 32'd1);
    check("sat load memrd", 32'(sbus.MemRead_EX), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
